// File: rtl/rotary_led_sequencer.sv
// Mode-sequenced LED controller for a rotary encoder. It turns detent events into a
// shift, count, bar or auto-scroll pattern on eight LEDs, and a push-button cycles the mode.
module rotary_led_sequencer #(
    parameter int PRESCALE = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rotation_event,
    input  logic       rotation_direction,
    input  logic       mode_btn,
    output logic [7:0] leds,
    output logic [1:0] mode
);
    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        MODE_SHIFT = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_BAR   = 2'd2,
        MODE_AUTO  = 2'd3
    } mode_t;

    mode_t           state;
    logic            sync1;
    logic            sync2;
    logic            btn_prev;
    logic            mode_press;
    logic [2:0]      pos;
    logic [7:0]      cnt;
    logic [3:0]      level;
    logic            auto_dir;
    logic [PS_W-1:0] prescaler;

    // Input semantics: rotation_event is a one-cycle strobe with no back-pressure;
    // rotation_direction is qualified by it and ignored otherwise.
    assign mode_press = sync2 & ~btn_prev;
    assign mode       = state;

    function automatic logic [7:0] one_hot(input logic [2:0] p);
        return 8'd1 << p;
    endfunction

    function automatic logic [7:0] thermo(input logic [3:0] l);
        logic [8:0] t;
        t = (9'd1 << l) - 9'd1;
        return t[7:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MODE_SHIFT;
            leds      <= 8'h01;
            pos       <= 3'd0;
            cnt       <= 8'd0;
            level     <= 4'd0;
            auto_dir  <= 1'b1;
            prescaler <= '0;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            btn_prev  <= 1'b0;
        end else begin
            sync1    <= mode_btn;
            sync2    <= sync1;
            btn_prev <= sync2;
            // A mode change takes precedence; any coincident event is dropped.
            if (mode_press) begin
                case (state)
                    MODE_SHIFT: begin
                        state <= MODE_COUNT;
                        cnt   <= 8'd0;
                        leds  <= 8'h00;
                    end
                    MODE_COUNT: begin
                        state <= MODE_BAR;
                        level <= 4'd0;
                        leds  <= 8'h00;
                    end
                    MODE_BAR: begin
                        state     <= MODE_AUTO;
                        pos       <= 3'd0;
                        auto_dir  <= 1'b1;
                        prescaler <= '0;
                        leds      <= 8'h01;
                    end
                    MODE_AUTO: begin
                        state     <= MODE_SHIFT;
                        pos       <= 3'd0;
                        prescaler <= '0;
                        leds      <= 8'h01;
                    end
                endcase
            end else begin
                case (state)
                    MODE_SHIFT: begin
                        if (rotation_event) begin
                            if (rotation_direction) begin
                                pos  <= pos + 3'd1;
                                leds <= one_hot(pos + 3'd1);
                            end else begin
                                pos  <= pos - 3'd1;
                                leds <= one_hot(pos - 3'd1);
                            end
                        end
                    end
                    MODE_COUNT: begin
                        if (rotation_event) begin
                            if (rotation_direction) begin
                                cnt  <= cnt + 8'd1;
                                leds <= cnt + 8'd1;
                            end else begin
                                cnt  <= cnt - 8'd1;
                                leds <= cnt - 8'd1;
                            end
                        end
                    end
                    MODE_BAR: begin
                        if (rotation_event) begin
                            if (rotation_direction && level != 4'd8) begin
                                level <= level + 4'd1;
                                leds  <= thermo(level + 4'd1);
                            end else if (!rotation_direction && level != 4'd0) begin
                                level <= level - 4'd1;
                                leds  <= thermo(level - 4'd1);
                            end
                        end
                    end
                    MODE_AUTO: begin
                        // An event only re-aims the scroll and restarts the timebase.
                        if (rotation_event) begin
                            auto_dir  <= rotation_direction;
                            prescaler <= '0;
                        end else if (prescaler == PS_LAST) begin
                            prescaler <= '0;
                            if (auto_dir) begin
                                pos  <= pos + 3'd1;
                                leds <= one_hot(pos + 3'd1);
                            end else begin
                                pos  <= pos - 3'd1;
                                leds <= one_hot(pos - 3'd1);
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule
